jk_cmd_queue: RTL

JK_CMD_QUEUE -- requirements
Module: jk_cmd_queue

---
 rtl/jk_cmd_queue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/jk_cmd_queue.sv
// Command FIFO feeding a bank of downstream JK flip-flops: each queued command
// drives J/K/E for repeat+1 cycles while a shadow copy of the flops' Q is kept.
module jk_cmd_queue #(
    parameter int WIDTHMINUSONE = 7,
    parameter int DEPTH         = 4
) (
    input  logic                   _clock,
    input  logic                   _reset,
    input  logic                   _cmd_valid,
    output logic                   _cmd_ready,
    input  logic [1:0]             _cmd_op,
    input  logic [WIDTHMINUSONE:0] _cmd_mask,
    input  logic [3:0]             _cmd_repeat,
    output logic [WIDTHMINUSONE:0] _J,
    output logic [WIDTHMINUSONE:0] _K,
    output logic [WIDTHMINUSONE:0] _E,
    output logic                   _busy,
    output logic [4:0]             _level,
    output logic [WIDTHMINUSONE:0] _return
);

    localparam int W  = WIDTHMINUSONE + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 2 + W + 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state_q;
    logic [3:0]      rep_q;
    logic [W-1:0]    j_q;
    logic [W-1:0]    k_q;
    logic [W-1:0]    e_q;
    logic [W-1:0]    ret_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [4:0]      level_q;
    logic [4:0]      level_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   head_s;
    logic            push_s;
    logic            pop_s;

    // Returns {J, K, E} for an operation applied to a mask.
    function automatic logic [3*W-1:0] drive_f(input logic [1:0] op, input logic [W-1:0] mask);
        logic [W-1:0] zero;
        zero = {W{1'b0}};
        case (op)
            2'b01:   drive_f = {mask, zero, mask};
            2'b10:   drive_f = {zero, mask, mask};
            2'b11:   drive_f = {mask, mask, mask};
            default: drive_f = {zero, zero, zero};
        endcase
    endfunction

    // Bitwise JK flip-flop next state with clock enable.
    function automatic logic [W-1:0] jk_next_f(input logic [W-1:0] q, input logic [W-1:0] j,
                                               input logic [W-1:0] k, input logic [W-1:0] e);
        jk_next_f = (~e & q) | (e & j & ~k) | (e & j & k & ~q) | (e & ~j & ~k & q);
    endfunction

    assign head_s     = mem_q[rd_ptr_q];
    assign _cmd_ready = (level_q < 5'(DEPTH));
    assign push_s     = _cmd_valid & _cmd_ready;
    assign _busy      = (level_q != 5'd0) | (state_q == ISSUE);
    assign _level     = level_q;
    assign _J         = j_q;
    assign _K         = k_q;
    assign _E         = e_q;
    assign _return    = ret_q;

    // Pop whenever the issue stage is free or finishing its last repeat.
    always_comb begin
        pop_s = 1'b0;
        if (level_q != 5'd0) begin
            case (state_q)
                IDLE:    pop_s = 1'b1;
                ISSUE:   pop_s = (rep_q == 4'd0);
                default: pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

    // Occupancy next state; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge _clock) begin
        if (!_reset && push_s) begin
            mem_q[wr_ptr_q] <= {_cmd_op, _cmd_mask, _cmd_repeat};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 5'd0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1'b1);
            end
            level_q <= level_d;
        end
    end

    // Issue FSM with registered J/K/E and the shadow Q register.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q <= IDLE;
            rep_q   <= 4'd0;
            j_q     <= '0;
            k_q     <= '0;
            e_q     <= '0;
            ret_q   <= '0;
        end else begin
            ret_q <= jk_next_f(ret_q, j_q, k_q, e_q);
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        {j_q, k_q, e_q} <= drive_f(head_s[EW-1 -: 2], head_s[W+3:4]);
                        rep_q           <= head_s[3:0];
                        state_q         <= ISSUE;
                    end else begin
                        j_q <= '0;
                        k_q <= '0;
                        e_q <= '0;
                    end
                end
                ISSUE: begin
                    if (rep_q != 4'd0) begin
                        rep_q <= rep_q - 4'd1;
                    end else if (pop_s) begin
                        {j_q, k_q, e_q} <= drive_f(head_s[EW-1 -: 2], head_s[W+3:4]);
                        rep_q           <= head_s[3:0];
                    end else begin
                        j_q     <= '0;
                        k_q     <= '0;
                        e_q     <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rep_q   <= 4'd0;
                    j_q     <= '0;
                    k_q     <= '0;
                    e_q     <= '0;
                end
            endcase
        end
    end

endmodule
